id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter STALL_CNT_W, default 16, width of the saturating load-use stall counter.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  decode slot holds a real instruction.
REQ-005 id_instr  input  32  decoded instruction word (opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0]).
REQ-006 id_read_data_1 / id_read_data_2  input  32 each  register-file read data for rs / rt.
REQ-007 id_jump_ext  input  32  sign-extended jump target from the register file.
REQ-008 flush  input  1  taken branch/jump in EX; kill the decode slot.
REQ-009 wb_regwrite, wb_reg_num, wb_data  input  1/5/32  write-back port, mirrored from the register-file write side.
REQ-010 ex_valid, ex_regwrite, ex_memread  output  1 each  EX-slot qualifiers.
REQ-011 ex_opcode  output  6; ex_rs_num, ex_rt_num, ex_dest_num  output  5 each.
REQ-012 ex_op_a, ex_op_b, ex_imm_ext, ex_jump_ext  output  32 each.
REQ-013 stall_if_id  output  1  hold PC and IF/ID this cycle.
REQ-014 stall_count  output  STALL_CNT_W  number of inserted load-use bubbles.

Function
REQ-015 Decode: regwrite = opcode in {OP_ALU_R 101000, OP_ADDI 110010, OP_LOAD 111011}; memread = (opcode == OP_LOAD); dest = rd for OP_ALU_R, otherwise rt.
REQ-016 Load-use hazard (combinational) = ex_valid & ex_memread & ex_dest_num != 0 & id_valid & (ex_dest_num == rs | ex_dest_num == rt).
REQ-017 stall_if_id = hazard & !flush; it is combinational with no latency.
REQ-018 Posedge priority is reset > flush > hazard > normal load.
REQ-019 Flush: ex_valid <= 0, ex_regwrite <= 0, ex_memread <= 0; other EX fields are don't-care.
REQ-020 Hazard: insert a bubble (same as flush) and stall_count increments, saturating at all-ones.
REQ-021 Normal: the EX slot loads the decoded fields from the ID inputs and ex_valid <= id_valid.
REQ-022 Normal: ex_regwrite and ex_memread are gated by id_valid.
REQ-023 Immediate: ex_imm_ext = {16{imm[15]}, imm}.
REQ-024 WB bypass: if wb_regwrite & wb_reg_num != 0 & wb_reg_num == rs, then ex_op_a <= wb_data, else id_read_data_1.
REQ-025 WB bypass applies identically to rt for ex_op_b.
REQ-026 Register 0: an operand sourced from register 0 always loads 32'd0, regardless of read data or bypass.
REQ-027 Latency: ID inputs appear on EX outputs exactly one cycle later.
REQ-028 A stall lasts exactly one cycle: after the bubble, ex_memread = 0, so the hazard clears on its own.
REQ-029 Flush and hazard in the same cycle: flush wins, stall_if_id = 0, and stall_count does not increment.

Reset
REQ-030 While reset is high at posedge, all registered outputs go to 0: ex_valid, ex_regwrite, ex_memread, all ex_* fields, and stall_count.
REQ-031 stall_if_id reads 0 in the cycle after reset because ex_valid = 0.
REQ-032 Reset asserted mid-stall discards the bubble and clears the counter; it takes no other recovery action.

Structure
REQ-033 Opcode constants (OP_ALU_R, OP_ADDI, OP_LOAD) and the 5-bit register-number width belong in a shared pipeline package used by decode, the register file and this stage.
REQ-034 One sub-module, load_use_detect, holds the REQ-016/017 combinational hazard logic; the stage registers, bypass muxes and counter stay in id_ex_stage.

Verification
REQ-035 Reset then idle: reset=1 for 2 cycles -> all outputs 0, stall_count = 0, stall_if_id = 0.
REQ-036 Pass-through: OP_ADDI rs=3, rt=5, imm=16'hFFFE, read_data_1 = 3 -> next cycle ex_op_a = 3, ex_imm_ext = 32'hFFFFFFFE, ex_dest_num = 5, ex_regwrite = 1.
REQ-037 Load-use: OP_LOAD dest r7, followed by OP_ALU_R rs=7 -> stall_if_id = 1 for one cycle, bubble in EX (ex_valid = 0), stall_count = 1; the ALU op enters EX the following cycle.
REQ-038 Flush vs hazard: same setup as REQ-037 with flush = 1 in the hazard cycle -> stall_if_id = 0, ex_valid = 0, stall_count unchanged.
REQ-039 WB bypass: wb_regwrite = 1, wb_reg_num = 4, wb_data = 32'hDEAD0001, ID rs = 4, read_data_1 = 0 -> ex_op_a = 32'hDEAD0001.
REQ-040 Register 0 and saturation: wb_reg_num = 0 write with ID rs = 0 -> ex_op_a = 0; with STALL_CNT_W = 2, 5 consecutive load-use stalls -> stall_count holds at 3.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared pipeline definitions used by decode, the register file and the
// ID/EX stage: opcode constants, register-number width, the decoded control
// bundle and small decode/bypass helpers.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int REG_NUM_W = 5;
  localparam int OPCODE_W  = 6;
  localparam int DATA_W    = 32;

  typedef logic [REG_NUM_W-1:0] reg_num_t;
  typedef logic [OPCODE_W-1:0]  opcode_t;
  typedef logic [DATA_W-1:0]    word_t;

  localparam opcode_t OP_ALU_R = 6'b101000;
  localparam opcode_t OP_ADDI  = 6'b110010;
  localparam opcode_t OP_LOAD  = 6'b111011;

  // Control fields derived from the opcode alone.
  typedef struct packed {
    logic     regwrite;
    logic     memread;
    reg_num_t dest;
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_ctrl(input opcode_t  op,
                                            input reg_num_t rt,
                                            input reg_num_t rd);
    dec_ctrl_t c;
    c.regwrite = (op == OP_ALU_R) || (op == OP_ADDI) || (op == OP_LOAD);
    c.memread  = (op == OP_LOAD);
    c.dest     = (op == OP_ALU_R) ? rd : rt;
    return c;
  endfunction

  // Operand select: register 0 is hard-wired to zero and beats everything;
  // otherwise a same-cycle write-back to the source register wins over the
  // (stale) register-file read data.
  function automatic word_t select_operand(input reg_num_t src,
                                           input word_t    rdata,
                                           input logic     wb_we,
                                           input reg_num_t wb_num,
                                           input word_t    wb_data);
    word_t v;
    if (src == '0)
      v = '0;
    else if (wb_we && (wb_num == src))
      v = wb_data;
    else
      v = rdata;
    return v;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detection between the EX slot (a load) and
// the instruction currently in decode.
//   i_ex_valid, i_ex_memread, i_ex_dest_num : EX-slot state
//   i_id_valid, i_id_rs_num, i_id_rt_num    : decode-slot sources
//   i_flush                                  : taken branch/jump in EX
//   o_hazard                                 : raw hazard (before flush)
//   o_stall_if_id                            : hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic     i_ex_valid,
  input  logic     i_ex_memread,
  input  reg_num_t i_ex_dest_num,
  input  logic     i_id_valid,
  input  reg_num_t i_id_rs_num,
  input  reg_num_t i_id_rt_num,
  input  logic     i_flush,
  output logic     o_hazard,
  output logic     o_stall_if_id
);

  logic w_src_match;

  // Both fields are compared regardless of whether the opcode actually reads
  // rt; a spurious one-cycle stall is harmless, a missed one is not.
  assign w_src_match = (i_ex_dest_num == i_id_rs_num) ||
                       (i_ex_dest_num == i_id_rt_num);

  assign o_hazard = i_ex_valid && i_ex_memread && (i_ex_dest_num != '0) &&
                    i_id_valid && w_src_match;

  // A flush kills the decode slot anyway, so there is nothing to hold.
  assign o_stall_if_id = o_hazard && !i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with opcode decode, write-back bypass, load-use
// bubble insertion and a saturating count of inserted bubbles.
//
// Flow semantics: this is a valid-only pipeline slot (no ready). id_valid
// qualifies the decode inputs; ex_valid qualifies every ex_* field one cycle
// later. Back-pressure toward fetch is stall_if_id, which is combinational:
// when high, the upstream must hold PC and IF/ID so the same decode inputs are
// presented again next cycle while a bubble enters EX.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   id_valid, id_instr              : decode slot
//   id_read_data_1/2, id_jump_ext   : register-file read data, jump target
//   flush                           : kill the decode slot
//   wb_regwrite/wb_reg_num/wb_data  : write-back port (bypass source)
//   ex_*                            : EX-slot registered fields
//   stall_if_id                     : hold PC and IF/ID this cycle
//   stall_count                     : saturating load-use bubble count
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [31:0]            id_instr,
  input  logic [31:0]            id_read_data_1,
  input  logic [31:0]            id_read_data_2,
  input  logic [31:0]            id_jump_ext,
  input  logic                   flush,
  input  logic                   wb_regwrite,
  input  logic [4:0]             wb_reg_num,
  input  logic [31:0]            wb_data,
  output logic                   ex_valid,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic [5:0]             ex_opcode,
  output logic [4:0]             ex_rs_num,
  output logic [4:0]             ex_rt_num,
  output logic [4:0]             ex_dest_num,
  output logic [31:0]            ex_op_a,
  output logic [31:0]            ex_op_b,
  output logic [31:0]            ex_imm_ext,
  output logic [31:0]            ex_jump_ext,
  output logic                   stall_if_id,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Instruction field split.
  opcode_t   w_opcode;
  reg_num_t  w_rs;
  reg_num_t  w_rt;
  reg_num_t  w_rd;
  logic [15:0] w_imm;

  assign w_opcode = id_instr[31:26];
  assign w_rs     = id_instr[25:21];
  assign w_rt     = id_instr[20:16];
  assign w_rd     = id_instr[15:11];
  assign w_imm    = id_instr[15:0];

  dec_ctrl_t w_ctrl;
  word_t     w_op_a;
  word_t     w_op_b;
  word_t     w_imm_ext;
  logic      w_hazard;

  assign w_ctrl    = decode_ctrl(w_opcode, w_rt, w_rd);
  assign w_op_a    = select_operand(w_rs, id_read_data_1, wb_regwrite,
                                    wb_reg_num, wb_data);
  assign w_op_b    = select_operand(w_rt, id_read_data_2, wb_regwrite,
                                    wb_reg_num, wb_data);
  assign w_imm_ext = {{16{w_imm[15]}}, w_imm};

  // EX-slot registers.
  logic                   r_ex_valid;
  logic                   r_ex_regwrite;
  logic                   r_ex_memread;
  opcode_t                r_ex_opcode;
  reg_num_t               r_ex_rs_num;
  reg_num_t               r_ex_rt_num;
  reg_num_t               r_ex_dest_num;
  word_t                  r_ex_op_a;
  word_t                  r_ex_op_b;
  word_t                  r_ex_imm_ext;
  word_t                  r_ex_jump_ext;
  logic [STALL_CNT_W-1:0] r_stall_count;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_ex_valid),
    .i_ex_memread  (r_ex_memread),
    .i_ex_dest_num (r_ex_dest_num),
    .i_id_valid    (id_valid),
    .i_id_rs_num   (w_rs),
    .i_id_rt_num   (w_rt),
    .i_flush       (flush),
    .o_hazard      (w_hazard),
    .o_stall_if_id (stall_if_id)
  );

  // Priority: reset > flush > hazard > normal load. Flush and hazard bubbles
  // only clear the qualifiers; the data fields simply hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_opcode   <= '0;
      r_ex_rs_num   <= '0;
      r_ex_rt_num   <= '0;
      r_ex_dest_num <= '0;
      r_ex_op_a     <= '0;
      r_ex_op_b     <= '0;
      r_ex_imm_ext  <= '0;
      r_ex_jump_ext <= '0;
      r_stall_count <= '0;
    end else if (flush) begin
      r_ex_valid    <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
    end else if (w_hazard) begin
      r_ex_valid    <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      if (r_stall_count != {STALL_CNT_W{1'b1}})
        r_stall_count <= r_stall_count + 1'b1;
    end else begin
      r_ex_valid    <= id_valid;
      r_ex_regwrite <= id_valid && w_ctrl.regwrite;
      r_ex_memread  <= id_valid && w_ctrl.memread;
      r_ex_opcode   <= w_opcode;
      r_ex_rs_num   <= w_rs;
      r_ex_rt_num   <= w_rt;
      r_ex_dest_num <= w_ctrl.dest;
      r_ex_op_a     <= w_op_a;
      r_ex_op_b     <= w_op_b;
      r_ex_imm_ext  <= w_imm_ext;
      r_ex_jump_ext <= id_jump_ext;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_regwrite = r_ex_regwrite;
  assign ex_memread  = r_ex_memread;
  assign ex_opcode   = r_ex_opcode;
  assign ex_rs_num   = r_ex_rs_num;
  assign ex_rt_num   = r_ex_rt_num;
  assign ex_dest_num = r_ex_dest_num;
  assign ex_op_a     = r_ex_op_a;
  assign ex_op_b     = r_ex_op_b;
  assign ex_imm_ext  = r_ex_imm_ext;
  assign ex_jump_ext = r_ex_jump_ext;
  assign stall_count = r_stall_count;

endmodule
